freq_meter: RTL and testbench

- Frequency measurement block: receives a free-running external square wave and counts its rising edges over a fixed gate window of 2^GATE_BITS clock cycles.
- At the end of each window it publishes the count with a one-cycle valid strobe.
- It is the receive/measure counterpart of the team's prescaled tick/counter generator: that block emits a divided rate, this one recovers a rate figure from an incoming signal.
- Sits between an asynchronous input pin and display/readout logic.

---
 rtl/freq_meter.sv | 106 ++++++++++
 tb/tb_freq_meter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous square wave over a gate
// window of 2^GATE_BITS enabled clock cycles and publishes the count with a
// one-cycle valid strobe. The edge counter saturates and flags overflow.
module freq_meter #(
    parameter int GATE_BITS = 25,
    parameter int COUNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               sig_in,
    output logic [COUNT_W-1:0] measure,
    output logic               measure_valid,
    output logic               overflow
);

    logic                 s1_q, s1_d;
    logic                 s2_q, s2_d;
    logic                 s3_q, s3_d;
    logic [GATE_BITS-1:0] gate_cnt_q, gate_cnt_d;
    logic [COUNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic                 sat_q, sat_d;
    logic [COUNT_W-1:0]   measure_q, measure_d;
    logic                 measure_valid_q, measure_valid_d;
    logic                 overflow_q, overflow_d;

    logic                 rise;
    logic                 edge_max;
    logic                 win_close;
    logic [COUNT_W-1:0]   edge_next;
    logic                 sat_next;

    // Next-state logic: synchronizer, gate/edge counting and window publish.
    always_comb begin
        // Two-flop synchronizer plus one delay flop for edge detection;
        // runs regardless of enable so the pipeline is always primed.
        s1_d = sig_in;
        s2_d = s1_q;
        s3_d = s2_q;

        rise      = s2_q & ~s3_q;
        edge_max  = &edge_cnt_q;
        win_close = (gate_cnt_q == {GATE_BITS{1'b1}});

        // Saturating increment; an edge arriving at full scale is lost and
        // marks the window as overflowed.
        edge_next = (rise && !edge_max) ? edge_cnt_q + COUNT_W'(1) : edge_cnt_q;
        sat_next  = sat_q | (rise & edge_max);

        gate_cnt_d      = gate_cnt_q;
        edge_cnt_d      = edge_cnt_q;
        sat_d           = sat_q;
        measure_d       = measure_q;
        overflow_d      = overflow_q;
        measure_valid_d = 1'b0;

        if (!enable) begin
            // Partial window is discarded; published results are held.
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            sat_d      = 1'b0;
        end else if (win_close) begin
            // A rise on the closing cycle still belongs to this window.
            measure_d       = edge_next;
            overflow_d      = sat_next;
            measure_valid_d = 1'b1;
            gate_cnt_d      = '0;
            edge_cnt_d      = '0;
            sat_d           = 1'b0;
        end else begin
            gate_cnt_d = gate_cnt_q + GATE_BITS'(1);
            edge_cnt_d = edge_next;
            sat_d      = sat_next;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q            <= 1'b0;
            s2_q            <= 1'b0;
            s3_q            <= 1'b0;
            gate_cnt_q      <= '0;
            edge_cnt_q      <= '0;
            sat_q           <= 1'b0;
            measure_q       <= '0;
            measure_valid_q <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            s1_q            <= s1_d;
            s2_q            <= s2_d;
            s3_q            <= s3_d;
            gate_cnt_q      <= gate_cnt_d;
            edge_cnt_q      <= edge_cnt_d;
            sat_q           <= sat_d;
            measure_q       <= measure_d;
            measure_valid_q <= measure_valid_d;
            overflow_q      <= overflow_d;
        end
    end

    assign measure       = measure_q;
    assign measure_valid = measure_valid_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: a 4-bit and a 3-bit counter instance share stimulus;
// a window-level reference model predicts every strobe, count and flag.
module tb_freq_meter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       sig_in;
    logic [3:0] m4_o;
    logic       v4_o, o4_o;
    logic [2:0] m3_o;
    logic       v3_o, o3_o;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    freq_meter #(.GATE_BITS(4), .COUNT_W(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
        .measure(m4_o), .measure_valid(v4_o), .overflow(o4_o)
    );

    freq_meter #(.GATE_BITS(4), .COUNT_W(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
        .measure(m3_o), .measure_valid(v3_o), .overflow(o3_o)
    );

    // Reference model: the sampled input history since reset, the number of
    // enabled edges and counted rises in the current window, and the last
    // published results for each counter width.
    bit hist[$];
    int wl, wr;
    int em4, em3;
    bit eo4, eo3, ev, amb3;

    typedef struct {
        int period;
        int m4;
        int o4;
        int m3;
        int o3;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit hget(input int i);
        if (i < 0) return 1'b0;
        return hist[i];
    endfunction

    function automatic bit sq(input int period, input int k);
        if (period == 0) return 1'b0;
        return ((k % period) < (period / 2));
    endfunction

    task automatic model_reset();
        hist.delete();
        wl = 0; wr = 0;
        em4 = 0; em3 = 0; eo4 = 0; eo3 = 0; ev = 0; amb3 = 0;
    endtask

    // A transition from 0 to 1 between samples n-3 and n-2 is seen at edge n.
    task automatic model_edge();
        int n;
        bit r;
        n = hist.size();
        r = hget(n - 2) && !hget(n - 3);
        hist.push_back(sig_in);
        if (enable) begin
            wl++;
            if (r) wr++;
            if (wl == 16) begin
                em4  = (wr > 15) ? 15 : wr;
                eo4  = (wr > 15);
                em3  = (wr > 7) ? 7 : wr;
                eo3  = (wr > 7);
                amb3 = (wr == 7);
                ev   = 1'b1;
                wl = 0; wr = 0;
            end else begin
                ev = 1'b0;
            end
        end else begin
            wl = 0; wr = 0; ev = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("valid4", int'(v4_o), int'(ev));
        chk("measure4", int'(m4_o), em4);
        chk("overflow4", int'(o4_o), int'(eo4));
        chk("valid3", int'(v3_o), int'(ev));
        chk("measure3", int'(m3_o), em3);
        if (!amb3) chk("overflow3", int'(o3_o), int'(eo3));
    endtask

    task automatic step(input logic en, input logic s);
        @(negedge clock);
        enable = en;
        sig_in = s;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_m4"}, int'(m4_o), 0);
        chk({nm, "_v4"}, int'(v4_o), 0);
        chk({nm, "_o4"}, int'(o4_o), 0);
        chk({nm, "_m3"}, int'(m3_o), 0);
        chk({nm, "_v3"}, int'(v3_o), 0);
        chk({nm, "_o3"}, int'(o3_o), 0);
    endtask

    // Asserts reset between clock edges, checks outputs clear immediately,
    // then releases it shortly after a rising edge with the given inputs.
    task automatic do_reset(input logic s_rel, input logic en_rel);
        #2 reset_n = 1'b0;
        #1 check_zero("async_reset");
        model_reset();
        sig_in = s_rel;
        enable = en_rel;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        int g;
        logic s;
        int prob;

        tbl[0] = '{period: 4,  m4: 4, o4: 0, m3: 4, o3: 0};
        tbl[1] = '{period: 2,  m4: 8, o4: 0, m3: 7, o3: 1};
        tbl[2] = '{period: 0,  m4: 0, o4: 0, m3: 0, o3: 0};
        tbl[3] = '{period: 8,  m4: 2, o4: 0, m3: 2, o3: 0};
        tbl[4] = '{period: 16, m4: 1, o4: 0, m3: 1, o3: 0};
        tbl[5] = '{period: 4,  m4: 4, o4: 0, m3: 4, o3: 0};

        reset_n = 1'b0;
        enable  = 1'b0;
        sig_in  = 1'b0;
        model_reset();
        #1 check_zero("por");
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;

        // Steady square waves: each entry spans two windows; the second
        // window sees only this entry's waveform.
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < 32; k++) begin
                step(1'b1, sq(tbl[e].period, k));
                if (k == 31) begin
                    chk("tbl_valid4", int'(v4_o), 1);
                    chk("tbl_measure4", int'(m4_o), tbl[e].m4);
                    chk("tbl_overflow4", int'(o4_o), tbl[e].o4);
                    chk("tbl_measure3", int'(m3_o), tbl[e].m3);
                    chk("tbl_overflow3", int'(o3_o), tbl[e].o3);
                end
            end
        end

        // Enable gap: drop enable on the gate_cnt=9 cycle for 5 cycles.
        g = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, sq(4, g)); g++;
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, sq(4, g)); g++;
            chk("gap_valid", int'(v4_o), 0);
            chk("gap_hold", int'(m4_o), 4);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, sq(4, g)); g++;
            chk("reen_valid", int'(v4_o), (i == 15) ? 1 : 0);
        end
        chk("reen_measure", int'(m4_o), 4);

        // Reset in the middle of a window while measure is non-zero.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, sq(4, g)); g++;
        end
        do_reset(1'b0, 1'b1);

        // Boundary edge: pulse timed so rise lands on the gate_cnt=15 cycle.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, (i == 13));
        chk("bound_measure4", int'(m4_o), 1);
        chk("bound_measure3", int'(m3_o), 1);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
        chk("bound_next4", int'(m4_o), 0);

        // Reset released with sig_in held high: one power-on edge.
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
        chk("pwr_valid", int'(v4_o), 1);
        chk("pwr_measure4", int'(m4_o), 1);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
        chk("pwr_next4", int'(m4_o), 0);

        // Randomized traffic checked every cycle against the model.
        s = 1'b0;
        prob = 50;
        for (int i = 0; i < 900; i++) begin
            if (i % 60 == 0) prob = $urandom_range(5, 100);
            if ($urandom_range(0, 99) < prob) s = ~s;
            if (i == 450) do_reset($urandom_range(0, 1) == 1, 1'b1);
            step($urandom_range(0, 24) != 0, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0 want 1 (run did not complete)");
        $fatal(1, "timeout");
    end

endmodule
